// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war match controller.
// The LFSR constants are only consumed when CPU_PLAYER_EN is defined.
package tow_pkg;

    typedef enum logic [1:0] {
        FIELD_RST  = 2'd0,
        PLAY       = 2'd1,
        HOLD       = 2'd2,
        MATCH_OVER = 2'd3
    } tow_state_e;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b01;
    localparam logic [1:0] WIN_RIGHT = 2'b10;

    localparam logic [9:0] LFSR_SEED   = 10'h001;
    localparam int         LFSR_TAP_HI = 9;
    localparam int         LFSR_TAP_LO = 6;

    // Fibonacci step for x^10 + x^7 + 1.
    function automatic logic [9:0] lfsr_next(input logic [9:0] v);
        return {v[8:0], v[LFSR_TAP_HI] ^ v[LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/key_pulse.sv
// Three-flop synchronizer for an asynchronous key with a rising-edge detect.
// A held key yields exactly one single-cycle pulse.
module key_pulse (
    input  logic clk,
    input  logic Reset,
    input  logic key_i,
    output logic pulse_o
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk) begin
        if (Reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= key_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign pulse_o = s2_q & ~s3_q;

endmodule

// File: rtl/tug_of_war_ctrl.sv
// Tug-of-war match controller: key conditioning, scoring, win hold and field reset.
// Optional macro CPU_PLAYER_EN adds cpu_mode and an LFSR-driven right player.
module tug_of_war_ctrl
    import tow_pkg::*;
#(
    parameter int SCORE_W     = 3,
    parameter int SCORE_MAX   = 7,
    parameter int HOLD_CYCLES = 25_000_000
`ifdef CPU_PLAYER_EN
    ,
    parameter logic [9:0] CPU_THRESH = 10'd16
`endif
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               key_left,
    input  logic               key_right,
`ifdef CPU_PLAYER_EN
    input  logic               cpu_mode,
`endif
    input  logic               left_win,
    input  logic               right_win,
    output logic               left_press,
    output logic               right_press,
    output logic               field_reset,
    output logic [SCORE_W-1:0] left_score,
    output logic [SCORE_W-1:0] right_score,
    output logic [1:0]         winner,
    output logic               match_over
);

    localparam int                 HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [SCORE_W-1:0] SMAX   = SCORE_W'(SCORE_MAX);
    localparam logic [HOLD_W-1:0]  HLOAD  = HOLD_W'(HOLD_CYCLES - 1);

    tow_state_e         state_q, state_d;
    logic [SCORE_W-1:0] left_score_q, left_score_d;
    logic [SCORE_W-1:0] right_score_q, right_score_d;
    logic [1:0]         winner_q, winner_d;
    logic               match_over_q, match_over_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               raw_left, raw_key_right, raw_right, tie;
    logic [SCORE_W-1:0] win_score;

    key_pulse u_key_left  (.clk(clk), .Reset(Reset), .key_i(key_left),  .pulse_o(raw_left));
    key_pulse u_key_right (.clk(clk), .Reset(Reset), .key_i(key_right), .pulse_o(raw_key_right));

`ifdef CPU_PLAYER_EN
    logic [9:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (Reset) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= lfsr_next(lfsr_q);
    end

    assign raw_right = cpu_mode ? (lfsr_q < CPU_THRESH) : raw_key_right;
`else
    assign raw_right = raw_key_right;
`endif

    assign tie       = raw_left & raw_right;
    assign win_score = (winner_q == WIN_LEFT) ? left_score_q : right_score_q;

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q       <= FIELD_RST;
            left_score_q  <= '0;
            right_score_q <= '0;
            winner_q      <= WIN_NONE;
            match_over_q  <= 1'b0;
            hold_q        <= '0;
        end else begin
            state_q       <= state_d;
            left_score_q  <= left_score_d;
            right_score_q <= right_score_d;
            winner_q      <= winner_d;
            match_over_q  <= match_over_d;
            hold_q        <= hold_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        left_score_d  = left_score_q;
        right_score_d = right_score_q;
        winner_d      = winner_q;
        match_over_d  = match_over_q;
        hold_d        = hold_q;
        left_press    = 1'b0;
        right_press   = 1'b0;
        field_reset   = 1'b0;

        case (state_q)
            FIELD_RST: begin
                field_reset = 1'b1;
                state_d     = PLAY;
            end
            PLAY: begin
                left_press  = raw_left & ~tie;
                right_press = raw_right & ~tie;
                if (left_win && !right_win) begin
                    left_score_d = (left_score_q == SMAX) ? SMAX : left_score_q + 1'b1;
                    winner_d     = WIN_LEFT;
                    hold_d       = HLOAD;
                    state_d      = HOLD;
                end else if (right_win && !left_win) begin
                    right_score_d = (right_score_q == SMAX) ? SMAX : right_score_q + 1'b1;
                    winner_d      = WIN_RIGHT;
                    hold_d        = HLOAD;
                    state_d       = HOLD;
                end else if (left_win && right_win) begin
                    winner_d = WIN_NONE;
                    state_d  = FIELD_RST;
                end
            end
            HOLD: begin
                if (hold_q == '0) begin
                    if (win_score == SMAX) begin
                        match_over_d = 1'b1;
                        state_d      = MATCH_OVER;
                    end else begin
                        winner_d = WIN_NONE;
                        state_d  = FIELD_RST;
                    end
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            MATCH_OVER: begin
                // A simultaneous press from both players starts a fresh match.
                if (tie) begin
                    left_score_d  = '0;
                    right_score_d = '0;
                    winner_d      = WIN_NONE;
                    match_over_d  = 1'b0;
                    state_d       = FIELD_RST;
                end
            end
            default: state_d = FIELD_RST;
        endcase

        if (Reset) begin
            left_press  = 1'b0;
            right_press = 1'b0;
            field_reset = 1'b1;
        end
    end

    assign left_score  = left_score_q;
    assign right_score = right_score_q;
    assign winner      = winner_q;
    assign match_over  = match_over_q;

endmodule

// File: tb/tb_tug_of_war_ctrl.sv
// Directed and randomized bench for tug_of_war_ctrl against a cycle-level match model.
module tb_tug_of_war_ctrl;

    localparam int SW   = 3;
    localparam int SMAX = 3;
    localparam int HOLD = 4;

    localparam int PH_FR   = 0;
    localparam int PH_PLAY = 1;
    localparam int PH_HOLD = 2;
    localparam int PH_OVER = 3;

    logic          clk = 1'b0;
    logic          Reset = 1'b1;
    logic          key_left = 1'b0, key_right = 1'b0;
    logic          left_win = 1'b0, right_win = 1'b0;
    logic          left_press, right_press, field_reset, match_over;
    logic [SW-1:0] left_score, right_score;
    logic [1:0]    winner;
`ifdef CPU_PLAYER_EN
    logic          cpu_mode = 1'b0;
`endif

    tug_of_war_ctrl #(.SCORE_W(SW), .SCORE_MAX(SMAX), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .Reset(Reset), .key_left(key_left), .key_right(key_right),
`ifdef CPU_PLAYER_EN
        .cpu_mode(cpu_mode),
`endif
        .left_win(left_win), .right_win(right_win),
        .left_press(left_press), .right_press(right_press), .field_reset(field_reset),
        .left_score(left_score), .right_score(right_score),
        .winner(winner), .match_over(match_over)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int lp_count = 0;
    int rp_count = 0;

    // Match model: phase, scores, hold cycles left, and per-key sample history (bit 0 newest).
    int       m_phase = PH_FR;
    int       m_ls = 0, m_rs = 0, m_win = 0, m_over = 0, m_hold = 0;
    bit [2:0] hl = '0, hr = '0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit kl, input bit kr, input bit lw, input bit rw);
        bit raw_l, raw_r;
        @(negedge clk);
        Reset = rst; key_left = kl; key_right = kr; left_win = lw; right_win = rw;
        #1;
        raw_l = hl[1] & ~hl[2];
        raw_r = hr[1] & ~hr[2];
        check_val("field_reset", 32'(field_reset), 32'(rst || m_phase == PH_FR));
        check_val("left_press", 32'(left_press), 32'(!rst && m_phase == PH_PLAY && raw_l && !raw_r));
        check_val("right_press", 32'(right_press), 32'(!rst && m_phase == PH_PLAY && raw_r && !raw_l));
        check_val("left_score", 32'(left_score), 32'(m_ls));
        check_val("right_score", 32'(right_score), 32'(m_rs));
        check_val("winner", 32'(winner), 32'(m_win));
        check_val("match_over", 32'(match_over), 32'(m_over));
        if (left_press === 1'b1) lp_count++;
        if (right_press === 1'b1) rp_count++;
        @(posedge clk);
        if (rst) begin
            m_phase = PH_FR; m_ls = 0; m_rs = 0; m_win = 0; m_over = 0; m_hold = 0;
            hl = '0; hr = '0;
        end else begin
            hl = {hl[1:0], kl};
            hr = {hr[1:0], kr};
            case (m_phase)
                PH_FR: m_phase = PH_PLAY;
                PH_PLAY: begin
                    if (lw && !rw) begin
                        m_ls = (m_ls < SMAX) ? m_ls + 1 : SMAX;
                        m_win = 1; m_hold = HOLD; m_phase = PH_HOLD;
                    end else if (rw && !lw) begin
                        m_rs = (m_rs < SMAX) ? m_rs + 1 : SMAX;
                        m_win = 2; m_hold = HOLD; m_phase = PH_HOLD;
                    end else if (lw && rw) begin
                        m_win = 0; m_phase = PH_FR;
                    end
                end
                PH_HOLD: begin
                    m_hold--;
                    if (m_hold == 0) begin
                        if (((m_win == 1) ? m_ls : m_rs) == SMAX) begin
                            m_over = 1; m_phase = PH_OVER;
                        end else begin
                            m_win = 0; m_phase = PH_FR;
                        end
                    end
                end
                default: begin
                    if (raw_l && raw_r) begin
                        m_ls = 0; m_rs = 0; m_win = 0; m_over = 0; m_phase = PH_FR;
                    end
                end
            endcase
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        int lp0, rp0;
        bit kl, kr;

        // Reset for two cycles; the first edge is unchecked since the DUT is unknown before it.
        @(posedge clk);
        step(1, 0, 0, 0, 0);
        idle(3);

        // Held left key gives exactly one press.
        lp0 = lp_count;
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0);
        idle(3);
        check_val("held_key_one_pulse", 32'(lp_count - lp0), 32'd1);

        // Both keys rising together: tie suppressed.
        lp0 = lp_count; rp0 = rp_count;
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0);
        idle(3);
        check_val("tie_no_press", 32'((lp_count - lp0) + (rp_count - rp0)), 32'd0);

        // Left point, with key activity during the hold.
        step(0, 0, 0, 1, 0);
        lp0 = lp_count;
        step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0); step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
        check_val("hold_blocks_press", 32'(lp_count - lp0), 32'd0);
        idle(3);

        // Three right points end the match.
        for (int w = 0; w < 3; w++) begin
            step(0, 0, 0, 0, 1);
            idle(6);
        end
        check_val("match_over_set", 32'(match_over), 32'd1);
        check_val("match_winner", 32'(winner), 32'd2);
        step(0, 0, 0, 1, 0); step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0); idle(3);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0);
        idle(3);
        check_val("new_match_cleared", 32'(match_over), 32'd0);

        // Reset in the middle of a hold.
        step(0, 0, 0, 1, 0);
        idle(2);
        step(1, 0, 0, 0, 0);
        idle(3);

        // Randomized play.
        kl = 0; kr = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) kl = ~kl;
            if ($urandom_range(0, 2) == 0) kr = ~kr;
            step(($urandom_range(0, 199) == 0), kl, kr,
                 ($urandom_range(0, 11) == 0), ($urandom_range(0, 11) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
